alu_muldiv_seq: RTL and testbench

Parametrised multi-cycle multiply/divide unit that extends the N-bit combinational ALU with the RV32M-style M operations. It uses one shared N-bit shift-add multiplier and one restoring divider datapath, with a start/busy/done handshake. It sits beside the ALU in the execute stage; control stalls the pipeline while `busy_o` is high and picks `result_o` when `done_o` pulses.

---
 rtl/alu_muldiv_seq_if.sv | 25 ++
 rtl/alu_muldiv_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// Handshake and operand bus between execute-stage control and the
// sequential multiply/divide unit.
interface alu_muldiv_seq_if #(
    parameter int unsigned N = 32
);
    logic         start_i;
    logic         abort_i;
    logic [2:0]   operacion_i;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic [N-1:0] resultado_o;
    logic         busy_o;
    logic         done_o;
    logic         dz_o;

    modport master (
        output start_i, abort_i, operacion_i, a_i, b_i,
        input  resultado_o, busy_o, done_o, dz_o
    );

    modport slave (
        input  start_i, abort_i, operacion_i, a_i, b_i,
        output resultado_o, busy_o, done_o, dz_o
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Sequential RV32M-style multiply/divide unit: shift-add multiplier and restoring
// divider sharing one 2N-bit working register, start/busy/done handshake.
module alu_muldiv_seq #(
    parameter int unsigned N = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    alu_muldiv_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    state_t         state_q;
    op_t            op_q;
    logic [CW-1:0]  cnt_q;
    logic [2*N-1:0] work_q;     // mul: {accumulator, multiplier}; div: {remainder, quotient}
    logic [N-1:0]   opnd_q;     // multiplicand or divisor magnitude
    logic           neg_res_q;
    logic           neg_rem_q;
    logic [N-1:0]   res_q;
    logic           busy_q;
    logic           done_q;
    logic           dz_q;

    op_t            op_in;
    logic           a_sgn, b_sgn, neg_res_in, neg_rem_in, dz_case, ovf_case;
    logic [N-1:0]   a_mag, b_mag, special_res;

    always_comb begin
        op_in      = op_t'(bus.operacion_i);
        a_sgn      = 1'b0;
        b_sgn      = 1'b0;
        neg_res_in = 1'b0;
        neg_rem_in = 1'b0;
        case (op_in)
            OP_MULH: begin
                a_sgn      = 1'b1;
                b_sgn      = 1'b1;
                neg_res_in = bus.a_i[N-1] ^ bus.b_i[N-1];
            end
            OP_MULHSU: begin
                a_sgn      = 1'b1;
                neg_res_in = bus.a_i[N-1];
            end
            OP_DIV, OP_REM: begin
                a_sgn      = 1'b1;
                b_sgn      = 1'b1;
                neg_res_in = bus.a_i[N-1] ^ bus.b_i[N-1];
                neg_rem_in = bus.a_i[N-1];
            end
            default: ;
        endcase
        a_mag    = (a_sgn && bus.a_i[N-1]) ? '0 - bus.a_i : bus.a_i;
        b_mag    = (b_sgn && bus.b_i[N-1]) ? '0 - bus.b_i : bus.b_i;
        dz_case  = op_in[2] && (bus.b_i == '0);
        ovf_case = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (bus.a_i == {1'b1, {(N-1){1'b0}}}) && (bus.b_i == '1);
        // Bit 1 of a divide opcode distinguishes remainder from quotient.
        if (dz_case) special_res = op_in[1] ? bus.a_i : '1;
        else         special_res = op_in[1] ? '0 : bus.a_i;
    end

    logic [N:0]     mul_sum, rem_shift, div_trial;
    logic [2*N-1:0] work_step, mul_full;
    logic [N-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        mul_sum   = {1'b0, work_q[2*N-1:N]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        rem_shift = work_q[2*N-1:N-1];
        div_trial = rem_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_trial[N]) work_step = {div_trial[N-1:0], work_q[N-2:0], 1'b1};
            else               work_step = {rem_shift[N-1:0], work_q[N-2:0], 1'b0};
        end else begin
            work_step = {mul_sum, work_q[N-1:1]};
        end
        mul_full = neg_res_q ? '0 - work_q : work_q;
        quo_fix  = neg_res_q ? '0 - work_q[N-1:0] : work_q[N-1:0];
        rem_fix  = neg_rem_q ? '0 - work_q[2*N-1:N] : work_q[2*N-1:N];
        case (op_q)
            OP_MUL:                       fix_res = mul_full[N-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = mul_full[2*N-1:N];
            OP_DIV, OP_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            work_q    <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else if (bus.abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        op_q      <= op_in;
                        cnt_q     <= '0;
                        neg_res_q <= neg_res_in;
                        neg_rem_q <= neg_rem_in;
                        busy_q    <= 1'b1;
                        if (op_in[2]) begin
                            work_q <= {{N{1'b0}}, a_mag};
                            opnd_q <= b_mag;
                        end else begin
                            work_q <= {{N{1'b0}}, b_mag};
                            opnd_q <= a_mag;
                        end
                        if (dz_case || ovf_case) begin
                            res_q   <= special_res;
                            dz_q    <= dz_case;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    work_q <= work_step;
                    if (cnt_q == CW'(N - 1)) state_q <= FIX;
                    else                     cnt_q   <= cnt_q + 1'b1;
                end
                FIX: begin
                    res_q   <= fix_res;
                    dz_q    <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.resultado_o = res_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.dz_o        = dz_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq at N=8 plus a randomised N=32 sweep
// against a wide-arithmetic reference.
module tb_alu_muldiv_seq;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq_if #(.N(8))  bus8 ();
    alu_muldiv_seq_if #(.N(32)) bus32 ();

    alu_muldiv_seq #(.N(8))  dut8  (.clk_i(clk), .rst_ni(rst_n), .bus(bus8));
    alu_muldiv_seq #(.N(32)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(bus32));

    // lat = rising edges after the accept edge at which done_o is first seen (-1 if never)
    task automatic do_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] res, output logic dz, output int lat, output int dones);
        @(negedge clk);
        bus8.operacion_i = op;
        bus8.a_i = a;
        bus8.b_i = b;
        bus8.start_i = 1'b1;
        @(posedge clk); #1;
        bus8.start_i = 1'b0;
        bus8.a_i = ~a;
        bus8.b_i = ~b;
        res = 'x; dz = 1'bx; lat = -1; dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus8.done_o) begin
                if (dones == 0) begin
                    lat = i; res = bus8.resultado_o; dz = bus8.dz_o;
                end
                dones++;
            end
            if (dones > 0 && !bus8.busy_o) break;
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [32:0] ref32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op[2] && b == 32'd0) return op[1] ? {1'b1, a} : {1'b1, 32'hFFFF_FFFF};
        case (op)
            OP_MUL:    begin p = ua * ub; return {1'b0, p[31:0]};  end
            OP_MULH:   begin p = sa * sb; return {1'b0, p[63:32]}; end
            OP_MULHSU: begin p = sa * ub; return {1'b0, p[63:32]}; end
            OP_MULHU:  begin p = ua * ub; return {1'b0, p[63:32]}; end
            OP_DIV:    begin p = sa / sb; return {1'b0, p[31:0]};  end
            OP_DIVU:   begin p = ua / ub; return {1'b0, p[31:0]};  end
            OP_REM:    begin p = sa % sb; return {1'b0, p[31:0]};  end
            default:   begin p = ua % ub; return {1'b0, p[31:0]};  end
        endcase
    endfunction

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus8.resultado_o !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", bus8.resultado_o); end
        checks++; if (bus8.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus8.busy_o); end
        checks++; if (bus8.done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus8.done_o); end
        checks++; if (bus8.dz_o !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", bus8.dz_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [7:0] r; logic d; int lat, dn;
        do_op8(OP_MUL, 8'd7, 8'd6, r, d, lat, dn);
        checks++; if (r !== 8'h2A) begin failures++; $display("FAIL mul_7x6 got=%h exp=2a", r); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL mul_latency got=%0d exp=9", lat); end
        checks++; if (dn !== 1) begin failures++; $display("FAIL mul_done_pulses got=%0d exp=1", dn); end
        do_op8(OP_MULHU, 8'd200, 8'd200, r, d, lat, dn);
        checks++; if (r !== 8'h9C) begin failures++; $display("FAIL mulhu_200x200 got=%h exp=9c", r); end
    endtask

    task automatic test_mulh_signed();
        logic [7:0] r; logic d; int lat, dn;
        do_op8(OP_MULH, 8'hFD, 8'h05, r, d, lat, dn);
        checks++; if (r !== 8'hFF) begin failures++; $display("FAIL mulh_m3x5 got=%h exp=ff", r); end
        do_op8(OP_MULHSU, 8'hFF, 8'hFF, r, d, lat, dn);
        checks++; if (r !== 8'hFF) begin failures++; $display("FAIL mulhsu_ffxff got=%h exp=ff", r); end
        do_op8(OP_MULH, 8'h80, 8'h80, r, d, lat, dn);
        checks++; if (r !== 8'h40) begin failures++; $display("FAIL mulh_80x80 got=%h exp=40", r); end
    endtask

    task automatic test_div();
        logic [7:0] r; logic d; int lat, dn;
        logic [2:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [7:0]  exps[4] = '{8'hFD, 8'hFF, 8'h7C, 8'h01};
        for (int k = 0; k < 4; k++) begin
            do_op8(ops[k], 8'hF9, 8'h02, r, d, lat, dn);
            checks++; if (r !== exps[k] || d !== 1'b0 || lat !== 9) begin
                failures++;
                $display("FAIL div_f9_by_2 op=%0d got=%h dz=%b lat=%0d exp=%h dz=0 lat=9", ops[k], r, d, lat, exps[k]);
            end
        end
    endtask

    task automatic test_special();
        logic [7:0] r; logic d; int lat, dn;
        logic [2:0] ops [5] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV};
        logic [7:0] as  [5] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h05};
        logic [7:0] bs  [5] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
        logic [7:0] exps[5] = '{8'hFF, 8'h80, 8'h80, 8'h00, 8'hFF};
        logic       dzs [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            do_op8(ops[k], as[k], bs[k], r, d, lat, dn);
            checks++; if (r !== exps[k] || d !== dzs[k] || lat !== 0 || dn !== 1) begin
                failures++;
                $display("FAIL special_case k=%0d got=%h dz=%b lat=%0d pulses=%0d exp=%h dz=%b lat=0 pulses=1",
                         k, r, d, lat, dn, exps[k], dzs[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r; logic d; int lat, dn;
        do_op8(OP_DIVU, 8'd100, 8'd7, r, d, lat, dn);
        checks++; if (r !== 8'h0E) begin failures++; $display("FAIL b2b_divu got=%h exp=0e", r); end
        do_op8(OP_REMU, 8'd100, 8'd7, r, d, lat, dn);
        checks++; if (r !== 8'h02 || lat !== 9) begin failures++; $display("FAIL b2b_remu got=%h lat=%0d exp=02 lat=9", r, lat); end
    endtask

    task automatic test_start_held();
        int dn = 0; logic [7:0] r = 'x; logic busy10 = 1'bx; bit seen = 0;
        @(negedge clk);
        bus8.operacion_i = OP_MUL; bus8.a_i = 8'd3; bus8.b_i = 8'd4; bus8.start_i = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i <= 10; i++) begin
            if (bus8.done_o) begin dn++; r = bus8.resultado_o; end
            if (i == 10) busy10 = bus8.busy_o;
            @(posedge clk); #1;
        end
        checks++; if (dn !== 1 || r !== 8'h0C) begin failures++; $display("FAIL held_start_single got pulses=%0d res=%h exp pulses=1 res=0c", dn, r); end
        checks++; if (busy10 !== 1'b0) begin failures++; $display("FAIL held_start_idle got busy=%b exp=0", busy10); end
        checks++; if (bus8.busy_o !== 1'b1) begin failures++; $display("FAIL held_start_reaccept got busy=%b exp=1", bus8.busy_o); end
        bus8.start_i = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus8.done_o) seen = 1;
        end
        checks++; if (!seen || bus8.resultado_o !== 8'h0C) begin failures++; $display("FAIL held_start_second got seen=%0d res=%h exp seen=1 res=0c", seen, bus8.resultado_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int dn = 0;
        @(negedge clk);
        bus8.operacion_i = OP_MUL; bus8.a_i = 8'd9; bus8.b_i = 8'd9; bus8.start_i = 1'b1;
        @(posedge clk); #1;
        bus8.start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus8.abort_i = 1'b1;
        @(posedge clk); #1;
        bus8.abort_i = 1'b0;
        checks++; if (bus8.busy_o !== 1'b0 || bus8.done_o !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%b done=%b exp 0 0", bus8.busy_o, bus8.done_o); end
        for (int i = 0; i < 14; i++) begin
            if (bus8.done_o) dn++;
            @(posedge clk); #1;
        end
        checks++; if (dn !== 0) begin failures++; $display("FAIL abort_no_done got pulses=%0d exp=0", dn); end
        checks++; if (bus8.resultado_o !== 8'h0C) begin failures++; $display("FAIL abort_result_kept got=%h exp=0c", bus8.resultado_o); end
    endtask

    task automatic test_async_reset();
        logic [7:0] r; logic d; int lat, dn;
        do_op8(OP_DIVU, 8'h80, 8'h00, r, d, lat, dn);
        @(negedge clk);
        bus8.operacion_i = OP_DIV; bus8.a_i = 8'hF9; bus8.b_i = 8'h02; bus8.start_i = 1'b1;
        @(posedge clk); #1;
        bus8.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus8.resultado_o !== 8'h00 || bus8.dz_o !== 1'b0 || bus8.busy_o !== 1'b0 || bus8.done_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got res=%h dz=%b busy=%b done=%b exp all 0", bus8.resultado_o, bus8.dz_o, bus8.busy_o, bus8.done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op8(OP_MUL, 8'd3, 8'd5, r, d, lat, dn);
        checks++; if (r !== 8'h0F || lat !== 9 || dn !== 1) begin failures++; $display("FAIL post_reset_mul got=%h lat=%0d pulses=%0d exp=0f lat=9 pulses=1", r, lat, dn); end
    endtask

    task automatic test_sweep32();
        logic [2:0] op; logic [31:0] a, b; logic [32:0] exp; bit seen;
        for (int n = 0; n < 1000; n++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 15))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'd1;
                default: ;
            endcase
            exp = ref32(op, a, b);
            @(negedge clk);
            bus32.operacion_i = op; bus32.a_i = a; bus32.b_i = b; bus32.start_i = 1'b1;
            @(posedge clk); #1;
            bus32.start_i = 1'b0;
            seen = 0;
            for (int i = 0; i < 60 && !seen; i++) begin
                if (bus32.done_o) seen = 1;
                else begin @(posedge clk); #1; end
            end
            checks++; if (!seen || {bus32.dz_o, bus32.resultado_o} !== exp) begin
                failures++;
                $display("FAIL sweep32 op=%0d a=%h b=%h got dz=%b res=%h seen=%0d exp dz=%b res=%h",
                         op, a, b, bus32.dz_o, bus32.resultado_o, seen, exp[32], exp[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus8.start_i = 1'b0;  bus8.abort_i = 1'b0;  bus8.operacion_i = '0;  bus8.a_i = '0;  bus8.b_i = '0;
        bus32.start_i = 1'b0; bus32.abort_i = 1'b0; bus32.operacion_i = '0; bus32.a_i = '0; bus32.b_i = '0;
        test_reset();
        test_mul();
        test_mulh_signed();
        test_div();
        test_special();
        test_back_to_back();
        test_start_held();
        test_abort();
        test_async_reset();
        test_sweep32();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
